// File: rtl/counter_pkg.sv
// Shared types and constants for the 4-bit counter checker.
package counter_pkg;

   // Width of the observed counter.
   localparam int CNT_W = 4;

   // Defaults for the checker parameters.
   localparam int ERR_W_DEF       = 8;
   localparam int LOSS_THRESH_DEF = 3;

   // Checker state: UNLOCKED holds no prediction, TRACK compares every edge.
   typedef enum logic {
      UNLOCKED = 1'b0,
      TRACK    = 1'b1
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset_n,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] value
);

   // Count up on inc, hold at all-ones, clear on clr or reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc && (value != {W{1'b1}})) begin
         value <= value + 1'b1;
      end
   end

endmodule

// File: rtl/counter_4bit_checker.sv
// Watches a 4-bit load/increment counter and flags any edge where the
// observed value differs from the value predicted at the previous edge.
//
// Handshake-free interface: inputs are sampled at every rising edge, and
// every output comes straight from a flop (locked is a decode of the state
// flop), so there is no combinational path from inputs to outputs.
module counter_4bit_checker
   import counter_pkg::*;
#(
   parameter int ERR_W       = ERR_W_DEF,
   parameter int LOSS_THRESH = LOSS_THRESH_DEF
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_data,
   input  logic [CNT_W-1:0] count,
   input  logic             clr_err,
   output logic             locked,
   output logic             mismatch,
   output logic             wrap,
   output logic [ERR_W-1:0] err_count
);

   // Run counter must be able to hold LOSS_THRESH itself.
   localparam int RUN_W = (LOSS_THRESH < 2) ? 1 : $clog2(LOSS_THRESH + 1);
   localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(LOSS_THRESH);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] exp_val, exp_nxt;
   logic [RUN_W-1:0] run_cnt, run_nxt, run_inc;
   logic             prev_inc15, prev_inc15_nxt;
   logic             mismatch_nxt, wrap_nxt;
   logic             cmp_miss;

   assign run_inc = run_cnt + 1'b1;
   assign locked  = (state == TRACK);

   // Next-state, prediction and pulse decode.
   always_comb begin
      state_nxt      = state;
      run_nxt        = run_cnt;
      mismatch_nxt   = 1'b0;
      wrap_nxt       = 1'b0;
      cmp_miss       = 1'b0;
      exp_nxt        = load ? load_data : (count + CNT_W'(1));
      // Remember whether this edge is a genuine 15 -> 0 increment step.
      prev_inc15_nxt = !load && (count == {CNT_W{1'b1}});

      case (state)
         UNLOCKED: begin
            state_nxt = TRACK;
            run_nxt   = '0;
         end
         TRACK: begin
            cmp_miss     = (count != exp_val);
            mismatch_nxt = cmp_miss;
            if (cmp_miss) begin
               if (run_inc == RUN_LIMIT) begin
                  // Too many misses in a row: drop the prediction.
                  state_nxt = UNLOCKED;
                  run_nxt   = '0;
               end else begin
                  run_nxt = run_inc;
               end
            end else begin
               run_nxt  = '0;
               wrap_nxt = prev_inc15 && (count == '0);
            end
         end
         default: begin
            state_nxt = UNLOCKED;
            run_nxt   = '0;
         end
      endcase
   end

   // State, prediction and output pulse registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= UNLOCKED;
         exp_val    <= '0;
         run_cnt    <= '0;
         prev_inc15 <= 1'b0;
         mismatch   <= 1'b0;
         wrap       <= 1'b0;
      end else begin
         state      <= state_nxt;
         exp_val    <= exp_nxt;
         run_cnt    <= run_nxt;
         prev_inc15 <= prev_inc15_nxt;
         mismatch   <= mismatch_nxt;
         wrap       <= wrap_nxt;
      end
   end

   sat_counter #(
      .W (ERR_W)
   ) u_err_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (cmp_miss),
      .clr     (clr_err),
      .value   (err_count)
   );

endmodule

// File: tb/tb_counter_4bit_checker.sv
// Bench for counter_4bit_checker: directed scenarios plus random traffic,
// checked every cycle against a history-based reference model.
module tb_counter_4bit_checker;

   localparam int ERR_W   = 8;
   localparam int LOSS    = 3;
   localparam int ERR_MAX = (1 << ERR_W) - 1;

   logic             clk = 1'b0;
   logic             reset_n;
   logic             load;
   logic [3:0]       load_data;
   logic [3:0]       count;
   logic             clr_err;
   logic             locked;
   logic             mismatch;
   logic             wrap;
   logic [ERR_W-1:0] err_count;

   int n_cmp  = 0;
   int n_fail = 0;
   bit check_en = 1'b0;
   int mis_tally  = 0;
   int wrap_tally = 0;

   logic [3:0] c = 4'd0;

   // model state
   int m_locked = 0, m_mis = 0, m_wrap = 0, m_err = 0, m_run = 0;
   int h_load = 0, h_ld = 0, h_cnt = 0;

   counter_4bit_checker #(
      .ERR_W       (ERR_W),
      .LOSS_THRESH (LOSS)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .load      (load),
      .load_data (load_data),
      .count     (count),
      .clr_err   (clr_err),
      .locked    (locked),
      .mismatch  (mismatch),
      .wrap      (wrap),
      .err_count (err_count)
   );

   // clock
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: the prediction is simply what the previous edge's
   // inputs say the counter must become.
   always @(posedge clk) begin
      int pred;
      if (!reset_n) begin
         m_locked = 0; m_mis = 0; m_wrap = 0; m_err = 0; m_run = 0;
      end else begin
         m_mis  = 0;
         m_wrap = 0;
         if (m_locked == 0) begin
            m_locked = 1;
            m_run    = 0;
         end else begin
            pred   = (h_load != 0) ? h_ld : (h_cnt + 1) % 16;
            m_mis  = (int'(count) != pred) ? 1 : 0;
            m_wrap = (m_mis == 0 && h_load == 0 && h_cnt == 15) ? 1 : 0;
            m_run  = (m_mis != 0) ? m_run + 1 : 0;
            if (m_run == LOSS) begin
               m_locked = 0;
               m_run    = 0;
            end
         end
         if (clr_err) m_err = 0;
         else if (m_mis != 0 && m_err < ERR_MAX) m_err = m_err + 1;
      end
      h_load = int'(load);
      h_ld   = int'(load_data);
      h_cnt  = int'(count);
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (check_en) begin
         check("locked",    int'(locked),    m_locked);
         check("mismatch",  int'(mismatch),  m_mis);
         check("wrap",      int'(wrap),      m_wrap);
         check("err_count", int'(err_count), m_err);
         mis_tally  += int'(mismatch);
         wrap_tally += int'(wrap);
      end
   end

   // driver tasks
   task automatic drive(input logic r, input logic ld, input logic [3:0] ldd,
                        input logic [3:0] cnt, input logic clr);
      reset_n = r; load = ld; load_data = ldd; count = cnt; clr_err = clr;
      @(posedge clk); #1;
   endtask

   task automatic inc_step();
      drive(1'b1, 1'b0, 4'd0, c, 1'b0);
      c = c + 4'd1;
   endtask

   task automatic load_step(input logic [3:0] v);
      drive(1'b1, 1'b1, v, c, 1'b0);
      c = v;
   endtask

   // A glitch that the counter itself follows: one bad value, then v+1 onward.
   task automatic glitch(input logic [3:0] v, input logic clr);
      drive(1'b1, 1'b0, 4'd0, v, clr);
      c = v + 4'd1;
   endtask

   initial begin
      logic [3:0] v;
      int guard;

      // reset
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      check_en = 1'b1;
      drive(1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      check("rst_locked", int'(locked), 0);
      check("rst_err", int'(err_count), 0);
      check("rst_mismatch", int'(mismatch), 0);
      c = 4'd0;

      // load 3 then 20 increments
      mis_tally = 0; wrap_tally = 0;
      load_step(4'd3);
      inc_step();
      check("lock_by_edge2", int'(locked), 1);
      for (int i = 0; i < 19; i++) inc_step();
      check("count_end", int'(c), 7);
      check("seq_mis_total", mis_tally, 0);
      check("seq_wrap_total", wrap_tally, 1);

      // single glitch 9 where 5 expected
      guard = 0;
      while (c != 4'd5 && guard < 20) begin inc_step(); guard++; end
      mis_tally = 0;
      glitch(4'd9, 1'b0);
      check("glitch_pulse", int'(mismatch), 1);
      for (int i = 0; i < 3; i++) inc_step();
      check("glitch_mis_total", mis_tally, 1);
      check("glitch_err", int'(err_count), 1);
      check("glitch_locked", int'(locked), 1);

      // three consecutive corrupted counts
      drive(1'b1, 1'b0, 4'd0, c, 1'b1);
      c = c + 4'd1;
      check("clr_err", int'(err_count), 0);
      mis_tally = 0;
      v = c + 4'd8;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 4'd0, v, 1'b0);
         c = c + 4'd1;
         if (i == 1) check("loss_locked_2nd", int'(locked), 1);
      end
      check("loss_locked_3rd", int'(locked), 0);
      inc_step();
      check("relock", int'(locked), 1);
      inc_step();
      inc_step();
      check("loss_mis_total", mis_tally, 3);
      check("loss_err", int'(err_count), 3);

      // loads equal to the increment, and a load of 0
      guard = 0;
      while (c != 4'd4 && guard < 20) begin inc_step(); guard++; end
      mis_tally = 0; wrap_tally = 0;
      load_step(4'd5);
      guard = 0;
      while (c != 4'd14 && guard < 20) begin inc_step(); guard++; end
      load_step(4'd0);
      for (int i = 0; i < 3; i++) inc_step();
      check("load_mis_total", mis_tally, 0);
      check("load_wrap_total", wrap_tally, 0);

      // saturation, then clear coincident with a mismatch
      for (int i = 0; i < 260; i++) begin
         glitch(4'(c + 4'd8), 1'b0);
         inc_step();
      end
      check("sat_err", int'(err_count), ERR_MAX);
      glitch(4'(c + 4'd8), 1'b0);
      check("sat_hold_err", int'(err_count), ERR_MAX);
      check("sat_hold_mis", int'(mismatch), 1);
      inc_step();
      glitch(4'(c + 4'd8), 1'b1);
      check("clr_win_err", int'(err_count), 0);
      check("clr_win_mis", int'(mismatch), 1);
      inc_step();

      // reset mid-track with a corrupted count
      drive(1'b0, 1'b0, 4'd0, 4'(c + 4'd8), 1'b0);
      check("midrst_mis", int'(mismatch), 0);
      check("midrst_locked", int'(locked), 0);
      check("midrst_wrap", int'(wrap), 0);
      check("midrst_err", int'(err_count), 0);
      c = 4'd0;
      inc_step();
      inc_step();
      check("midrst_relock", int'(locked), 1);

      // random traffic
      for (int i = 0; i < 800; i++) begin
         logic r, ld, clr;
         logic [3:0] ldd, cnt;
         r   = ($urandom_range(0, 49) != 0);
         ld  = ($urandom_range(0, 3) == 0);
         ldd = 4'($urandom_range(0, 15));
         clr = ($urandom_range(0, 29) == 0);
         cnt = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : c;
         drive(r, ld, ldd, cnt, clr);
         if (!r) c = 4'd0;
         else    c = ld ? ldd : cnt + 4'd1;
      end

      @(negedge clk);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
